// File: rtl/pio_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pio_pkg : shared PIO bus widths, request type and master FSM states. Rev 1.0
// ----------------------------------------------------------------------------
package pio_pkg;

    localparam int          PIO_ADDR_W   = 16;
    localparam int          PIO_DATA_W   = 32;
    localparam logic [31:0] PIO_ERR_DATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic                  rw;
        logic [PIO_ADDR_W-1:0] addr;
        logic [PIO_DATA_W-1:0] wdata;
    } pio_req_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } pio_state_e;

endpackage
`default_nettype wire

// File: rtl/pio_req_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pio_req_fifo : small synchronous request FIFO, push allowed when full+pop. Rev 1.0
// ----------------------------------------------------------------------------
module pio_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pio_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pio_master : PIO bus initiator, one request in flight, read timeout. Rev 1.0
// Optional request FIFO in front of the FSM: PIO_MASTER_REQ_FIFO_EN.
// ----------------------------------------------------------------------------
module pio_master
    import pio_pkg::*;
#(
    parameter int                ADDR_W      = PIO_ADDR_W,
    parameter int                DATA_W      = PIO_DATA_W,
    parameter int                TIMEOUT_CYC = 16,
    parameter logic [DATA_W-1:0] ERR_DATA    = PIO_ERR_DATA
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_vld,
    output logic              req_rdy,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              pio_cmd_vld,
    output logic              pio_rw,
    output logic [ADDR_W-1:0] pio_addr,
    output logic [DATA_W-1:0] pio_data_w,
    input  logic [DATA_W-1:0] pio_data_r,
    input  logic              pio_rd_vld
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    pio_state_e        state;
    pio_state_e        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              expired;
    logic              take;
    logic              src_vld;
    logic              src_rw;
    logic [ADDR_W-1:0] src_addr;
    logic [DATA_W-1:0] src_wdata;

`ifdef PIO_MASTER_REQ_FIFO_EN
    localparam int REQ_W = 1 + ADDR_W + DATA_W;

    logic             fifo_full;
    logic             fifo_empty;
    logic [REQ_W-1:0] fifo_head;

    pio_req_fifo #(
        .DEPTH (4),
        .WIDTH (REQ_W)
    ) u_req_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req_vld && req_rdy),
        .din   ({req_rw, req_addr, req_wdata}),
        .full  (fifo_full),
        .pop   (take),
        .dout  (fifo_head),
        .empty (fifo_empty)
    );

    assign req_rdy = !fifo_full;
    assign src_vld = !fifo_empty;
    assign {src_rw, src_addr, src_wdata} = fifo_head;
`else
    assign req_rdy   = (state == IDLE);
    assign src_vld   = req_vld;
    assign src_rw    = req_rw;
    assign src_addr  = req_addr;
    assign src_wdata = req_wdata;
`endif

    assign take        = (state == IDLE) && src_vld;
    assign expired     = (cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign pio_cmd_vld = (state == ISSUE);
    assign rsp_vld     = (state == RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (src_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = pio_rw ? RESP : WAIT_RD;
            WAIT_RD: if (pio_rd_vld || expired) state_nxt = RESP;
            RESP:    if (rsp_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus fields load only on accept, so they hold their last values outside ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            pio_rw     <= 1'b0;
            pio_addr   <= '0;
            pio_data_w <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            cnt        <= '0;
        end else begin
            if (take) begin
                pio_rw     <= src_rw;
                pio_addr   <= src_addr;
                pio_data_w <= src_wdata;
            end
            case (state)
                ISSUE: begin
                    cnt <= '0;
                    if (pio_rw) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                WAIT_RD: begin
                    if (pio_rd_vld) begin
                        rsp_rdata <= pio_data_r;
                        rsp_err   <= 1'b0;
                    end else if (expired) begin
                        rsp_rdata <= ERR_DATA;
                        rsp_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pio_master.sv
`default_nettype none
// tb_pio_master : randomized scoreboard bench; expected commands/responses come
// from a transaction-level model of the request plan and responder timing.
module tb_pio_master;
    import pio_pkg::*;

    localparam int          T   = 16;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_vld, req_rdy, req_rw;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_vld, rsp_rdy, rsp_err;
    logic [31:0] rsp_rdata;
    logic        pio_cmd_vld, pio_rw, pio_rd_vld;
    logic [15:0] pio_addr;
    logic [31:0] pio_data_w, pio_data_r;

    pio_master #(.ADDR_W(16), .DATA_W(32), .TIMEOUT_CYC(T), .ERR_DATA(ERR)) dut (
        .clk(clk), .reset(reset),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .pio_cmd_vld(pio_cmd_vld), .pio_rw(pio_rw), .pio_addr(pio_addr),
        .pio_data_w(pio_data_w), .pio_data_r(pio_data_r), .pio_rd_vld(pio_rd_vld)
    );

    // delay: cycles after the command at which the responder raises rd_vld; 0 = silent
    typedef struct { pio_req_t req; logic [31:0] rdata; int delay; int acc; } plan_t;
    typedef struct { logic [31:0] rdata; logic err; int due; } exp_rsp_t;

    plan_t       cmd_q[$];
    exp_rsp_t    rsp_q[$];
    int          cyc = 0, checks = 0, passed = 0, cmd_count = 0, rdy_mode = 0;
    logic        rsp_pending = 1'b0, rd_pending = 1'b0, prev_cmd = 1'b0;
    int          rd_at = 0;
    logic [31:0] rd_data = '0;
    logic        last_rw = 1'b0;
    logic [15:0] last_addr = '0;
    logic [31:0] last_wdata = '0;

    always #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end
    initial begin #1_000_000; $display("FAIL watchdog: sim time exceeded"); $fatal(1); end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    function automatic plan_t mk(input logic rw, input logic [15:0] a, input logic [31:0] wd,
                                 input logic [31:0] rd, input int d);
        plan_t p;
        p.req.rw = rw; p.req.addr = a; p.req.wdata = wd;
        p.rdata = rd; p.delay = d; p.acc = 0;
        return p;
    endfunction

    initial begin
        pio_rd_vld = 1'b0; pio_data_r = '0;
        forever begin
            @(posedge clk); #1;
            if (rd_pending && cyc == rd_at) begin
                pio_rd_vld = 1'b1; pio_data_r = rd_data; rd_pending = 1'b0;
            end else begin
                pio_rd_vld = 1'b0; pio_data_r = $urandom;
            end
        end
    end

    initial begin
        rsp_rdy = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       rsp_rdy = 1'b1;
                1:       rsp_rdy = ($urandom_range(0, 3) != 0);
                default: rsp_rdy = 1'b0;
            endcase
        end
    end

    // Command monitor: checks bus command against the plan and predicts the response.
    initial forever begin
        plan_t    p;
        exp_rsp_t e;
        @(negedge clk);
        if (reset) begin
            prev_cmd = 1'b0; last_rw = 1'b0; last_addr = '0; last_wdata = '0;
        end else if (pio_cmd_vld) begin
            check("cmd_single_cycle", prev_cmd, 0);
            cmd_count++;
            if (cmd_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_cmd: got addr %0h required no command", pio_addr);
            end else begin
                p = cmd_q.pop_front();
                check("cmd_rw", pio_rw, p.req.rw);
                check("cmd_addr", pio_addr, p.req.addr);
                check("cmd_data_w", pio_data_w, p.req.wdata);
`ifndef PIO_MASTER_REQ_FIFO_EN
                check("cmd_latency", cyc, p.acc + 1);
`endif
                if (p.req.rw) begin
                    e.rdata = '0; e.err = 1'b0; e.due = cyc + 1;
                end else if (p.delay >= 1 && p.delay <= T) begin
                    e.rdata = p.rdata; e.err = 1'b0; e.due = cyc + 1 + p.delay;
                end else begin
                    e.rdata = ERR; e.err = 1'b1; e.due = cyc + 1 + T;
                end
                if (!p.req.rw && p.delay > 0) begin
                    rd_pending = 1'b1;
                    rd_at      = cyc + p.delay;
                    rd_data    = (p.delay <= T) ? p.rdata : $urandom;
                end
                rsp_q.push_back(e);
                last_rw = p.req.rw; last_addr = p.req.addr; last_wdata = p.req.wdata;
            end
            prev_cmd = 1'b1;
        end else begin
            check("pio_rw_hold", pio_rw, last_rw);
            check("pio_addr_hold", pio_addr, last_addr);
            check("pio_data_w_hold", pio_data_w, last_wdata);
            prev_cmd = 1'b0;
        end
    end

    // Response monitor: pops the prediction on rsp_vld rise and holds it until handshake.
    initial forever begin
        exp_rsp_t cur;
        logic     cur_ok;
        @(negedge clk);
        if (reset) begin
            rsp_pending = 1'b0;
        end else begin
            if (rsp_vld && !rsp_pending) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_rsp: got rdata %0h required no response", rsp_rdata);
                    cur_ok = 1'b0;
                end else begin
                    cur = rsp_q.pop_front();
                    cur_ok = 1'b1;
                    check("rsp_latency", cyc, cur.due);
                end
                rsp_pending = 1'b1;
            end
            if (rsp_pending) begin
                if (!rsp_vld) begin
                    checks++;
                    $display("FAIL rsp_dropped: got rsp_vld 0 required 1");
                    rsp_pending = 1'b0;
                end else begin
                    if (cur_ok) begin
                        check("rsp_rdata", rsp_rdata, cur.rdata);
                        check("rsp_err", rsp_err, cur.err);
                    end
                    check("rsp_no_cmd", pio_cmd_vld, 0);
`ifndef PIO_MASTER_REQ_FIFO_EN
                    check("req_rdy_busy", req_rdy, 0);
`endif
                    if (rsp_rdy) rsp_pending = 1'b0;
                end
            end
        end
    end

    task automatic do_req(input plan_t p);
        int w;
        w = 0;
        req_vld = 1'b1; req_rw = p.req.rw; req_addr = p.req.addr; req_wdata = p.req.wdata;
        @(negedge clk);
        while (!req_rdy && w < 400) begin @(negedge clk); w++; end
        if (!req_rdy) begin
            checks++;
            $display("FAIL req_accept_timeout: got req_rdy 0 required 1");
            req_vld = 1'b0;
            return;
        end
        p.acc = cyc;
        cmd_q.push_back(p);
        @(posedge clk); #1;
        req_vld = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((cmd_q.size() != 0 || rsp_q.size() != 0 || rsp_pending || rd_pending || req_vld)
               && w < 2000) begin
            @(negedge clk); w++;
        end
        if (w >= 2000) begin
            checks++;
            $display("FAIL drain_timeout: got %0d pending responses required 0", rsp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_req_rdy", req_rdy, 1);
        check("rst_rsp_vld", rsp_vld, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_cmd_vld", pio_cmd_vld, 0);
        check("rst_pio_rw", pio_rw, 0);
        check("rst_pio_addr", pio_addr, 0);
        check("rst_pio_data_w", pio_data_w, 0);
    endtask

    initial begin
        int w, n, r, d;
        logic rw;
        req_vld = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        reset = 1'b0;

        rdy_mode = 0;
        do_req(mk(1'b1, 16'h0000, 32'h1234_5678, 32'h0, 0));        drain();
        do_req(mk(1'b0, 16'h0010, 32'h0, 32'hCAFE_F00D, 1));         drain();
        do_req(mk(1'b0, 16'h0020, 32'h0, 32'h1111_2222, T + 2));     drain();
        do_req(mk(1'b0, 16'h0030, 32'h0, 32'h3333_4444, T));         drain();
        do_req(mk(1'b0, 16'h0040, 32'h0, 32'h5555_6666, T + 1));     drain();

        // Backpressure with a second request waiting behind the held response
        rdy_mode = 2;
        do_req(mk(1'b1, 16'h0050, 32'hA5A5_0001, 32'h0, 0));
        fork
            do_req(mk(1'b1, 16'h0051, 32'hA5A5_0002, 32'h0, 0));
        join_none
        w = 0;
        @(negedge clk);
        while (!rsp_vld && w < 50) begin @(negedge clk); w++; end
        check("bp_rsp_seen", rsp_vld, 1);
        n = cmd_count;
        repeat (5) begin
            @(negedge clk);
            check("bp_rsp_vld", rsp_vld, 1);
            check("bp_no_new_cmd", cmd_count, n);
        end
        rdy_mode = 0;
        drain();

        // Reset while waiting on a silent responder
        do_req(mk(1'b0, 16'h0BAD, 32'h0, 32'h0, 0));
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        cmd_q.delete(); rsp_q.delete(); rd_pending = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        reset = 1'b0;
        do_req(mk(1'b0, 16'h0BEE, 32'h0, 32'h5A5A_A5A5, 2));         drain();

`ifdef PIO_MASTER_REQ_FIFO_EN
        rdy_mode = 2;
        for (int i = 0; i < 5; i++)
            do_req(mk(1'b0, 16'h0100 + 16'(i), 32'h0, 32'hF1F0_0000 + 32'(i), 1));
        @(negedge clk);
        check("fifo_full_rdy", req_rdy, 0);
        rdy_mode = 0;
        drain();
`endif

        rdy_mode = 1;
        repeat (60) begin
            r  = $urandom_range(0, 9);
            rw = 1'($urandom_range(0, 1));
            if (r <= 5)      d = $urandom_range(1, 4);
            else if (r == 6) d = T;
            else if (r == 7) d = T + 1;
            else if (r == 8) d = T + 2;
            else             d = 0;
            do_req(mk(rw, 16'($urandom), $urandom, $urandom, rw ? 0 : d));
            n = $urandom_range(0, 2);
            if (n > 0) begin repeat (n) @(posedge clk); #1; end
        end
        rdy_mode = 0;
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
